// File: rtl/song_pkg.sv
// Shared definitions for the melody-game word interface: state encoding,
// song geometry and keypad / LFSR helper functions.
package song_pkg;

  localparam int NOTE_W    = 4;
  localparam int NUM_NOTES = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RECORD = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_WRITE  = 3'd3;
  localparam logic [2:0] ST_START  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Keys 1..8 carry notes; 0 and 9..15 are not notes.
  function automatic logic key_valid(input logic [3:0] k);
    return (k >= 4'd1) && (k <= 4'd8);
  endfunction

  // Note index is the key code minus one.
  function automatic logic [2:0] key_to_note(input logic [3:0] k);
    logic [3:0] n;
    n = k - 4'd1;
    return n[2:0];
  endfunction

  // One step of the x^16+x^14+x^13+x^11+1 Fibonacci LFSR, shifting right.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Enable-gated tick generator: one-cycle tick every TICK_CYCLES enabled
// cycles. The count restarts from zero whenever en is low.
module tick_gen #(
  parameter int TICK_CYCLES = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Free count while enabled, wrapping at TICK_CYCLES-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             cnt <= '0;
    else if (!en)          cnt <= '0;
    else if (cnt == LAST)  cnt <= '0;
    else                   cnt <= cnt + CW'(1);
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/song_recorder.sv
// Writer side of the melody-game word interface. Records up to eight keypad
// notes into a 32-bit song word, then strobes write_enable and game_start.
// Optional feature macro SONG_RANDOM_FILL_EN: pad unrecorded slots from an
// LFSR and accept commit at any note count; otherwise pad with the last note.
module song_recorder
  import song_pkg::*;
#(
  parameter int TICK_CYCLES = 5000000,
  parameter int DELAY_TICKS = 2,
  parameter int MIN_NOTES   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  keypad_input,
  input  logic        keypad_enable,
  input  logic        commit,
  input  logic        clear,
  output logic [31:0] data_out,
  output logic        write_enable,
  output logic        game_start,
  output logic [3:0]  piezo_out,
  output logic [3:0]  led_out,
  output logic [3:0]  note_count,
  output logic        recording
);

  localparam int TW = $clog2(DELAY_TICKS + 1) + 1;

  logic [2:0]    state_q, state_d;
  logic          kp_prev;
  logic          key_rise, take_key, commit_go, in_entry;
  logic          tick, tick_en;
  logic [TW-1:0] tick_cnt;
  logic          pad_busy;
  logic [2:0]    pad_idx;
  logic [2:0]    fill_note;
  logic          we_d, gs_d, rec_d;

  assign in_entry = (state_q == ST_IDLE) || (state_q == ST_RECORD);
  assign key_rise = keypad_enable && !kp_prev;

`ifdef SONG_RANDOM_FILL_EN
  assign commit_go = commit && !clear && in_entry;
`else
  assign commit_go = commit && !clear && (state_q == ST_RECORD) &&
                     (int'(note_count) >= MIN_NOTES);
`endif

  // A key edge loses to commit in the same cycle.
  assign take_key = key_rise && key_valid(keypad_input) && !clear &&
                    !commit_go && in_entry;

  assign tick_en = (state_q == ST_WAIT) && !clear;

  tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (tick_en),
    .tick  (tick)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; clear overrides everything.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (commit_go)     state_d = ST_WAIT;
          else if (take_key) state_d = ST_RECORD;
        end
        ST_RECORD: begin
          if (commit_go)                            state_d = ST_WAIT;
          else if (take_key && note_count == 4'd7)  state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (tick_cnt == TW'(DELAY_TICKS) && !pad_busy) state_d = ST_WRITE;
        end
        ST_WRITE: state_d = ST_START;
        ST_START: state_d = ST_DONE;
        ST_DONE:  state_d = ST_DONE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Output decode from the upcoming state so the strobes leave a register.
  always_comb begin
    we_d  = (state_d == ST_WRITE);
    gs_d  = (state_d == ST_START);
    rec_d = (state_d == ST_RECORD);
  end

  // Registered strobes and status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_enable <= 1'b0;
      game_start   <= 1'b0;
      recording    <= 1'b0;
    end else begin
      write_enable <= we_d;
      game_start   <= gs_d;
      recording    <= rec_d;
    end
  end

`ifdef SONG_RANDOM_FILL_EN
  logic [15:0] lfsr_q;

  // LFSR steps every cycle; each padding cycle consumes one step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      lfsr_q <= LFSR_SEED;
    else if (clear) lfsr_q <= LFSR_SEED;
    else            lfsr_q <= lfsr_next(lfsr_q);
  end

  assign fill_note = lfsr_q[2:0];
`else
  logic [2:0] last_note_q;

  // Remember the most recent note for repeat-padding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         last_note_q <= 3'd0;
    else if (clear)    last_note_q <= 3'd0;
    else if (take_key) last_note_q <= key_to_note(keypad_input);
  end

  assign fill_note = last_note_q;
`endif

  // Song word, note count, key echo, padding loop and delay tick count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kp_prev    <= 1'b0;
      data_out   <= '0;
      note_count <= '0;
      piezo_out  <= '0;
      tick_cnt   <= '0;
      pad_busy   <= 1'b0;
      pad_idx    <= '0;
    end else begin
      kp_prev <= keypad_enable;
      if (clear) begin
        data_out   <= '0;
        note_count <= '0;
        piezo_out  <= '0;
        tick_cnt   <= '0;
        pad_busy   <= 1'b0;
        pad_idx    <= '0;
      end else begin
        if (take_key) begin
          data_out[{note_count[2:0], 2'b00} +: NOTE_W] <= {1'b0, key_to_note(keypad_input)};
          note_count <= note_count + 4'd1;
          piezo_out  <= keypad_input;
        end else if (!keypad_enable) begin
          piezo_out  <= '0;
        end

        // Padding walks the unrecorded slots one per cycle during WAIT.
        if (commit_go) begin
          pad_busy <= 1'b1;
          pad_idx  <= note_count[2:0];
        end else if (state_q == ST_WAIT && pad_busy) begin
          data_out[{pad_idx, 2'b00} +: NOTE_W] <= {1'b0, fill_note};
          pad_idx <= pad_idx + 3'd1;
          if (pad_idx == 3'd7) pad_busy <= 1'b0;
        end

        // Saturating so a fast tick can never skip past the target.
        if (state_q != ST_WAIT)
          tick_cnt <= '0;
        else if (tick && tick_cnt != TW'(DELAY_TICKS))
          tick_cnt <= tick_cnt + TW'(1);
      end
    end
  end

  assign led_out = piezo_out;

endmodule

// File: tb/tb_song_recorder.sv
// Self-checking bench for song_recorder with a short tick period.
module tb_song_recorder;

  localparam int TICK = 4;
  localparam int DLY  = 2;
  localparam int MINN = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  keypad_input;
  logic        keypad_enable;
  logic        commit;
  logic        clear;
  logic [31:0] data_out;
  logic        write_enable;
  logic        game_start;
  logic [3:0]  piezo_out;
  logic [3:0]  led_out;
  logic [3:0]  note_count;
  logic        recording;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] exp_q[$];

  song_recorder #(.TICK_CYCLES(TICK), .DELAY_TICKS(DLY), .MIN_NOTES(MINN)) dut (
    .clk           (clk),
    .reset         (reset),
    .keypad_input  (keypad_input),
    .keypad_enable (keypad_enable),
    .commit        (commit),
    .clear         (clear),
    .data_out      (data_out),
    .write_enable  (write_enable),
    .game_start    (game_start),
    .piezo_out     (piezo_out),
    .led_out       (led_out),
    .note_count    (note_count),
    .recording     (recording)
  );

  always #5 clk = ~clk;

  // Reference LFSR: seed on reset/clear, one right-shift step per clock.
  logic [15:0] mdl_lfsr;
  always @(posedge clk or posedge reset) begin
    if (reset || clear) mdl_lfsr <= 16'hACE1;
    else mdl_lfsr <= (mdl_lfsr >> 1) |
                     (16'((mdl_lfsr ^ (mdl_lfsr >> 2) ^ (mdl_lfsr >> 3) ^ (mdl_lfsr >> 5)) & 16'd1) << 15);
  end

  task automatic press(input logic [3:0] k, input int hold);
    keypad_input  = k;
    keypad_enable = 1'b1;
    repeat (hold) @(negedge clk);
    keypad_enable = 1'b0;
    keypad_input  = 4'd0;
    @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
  endtask

  // Waits (bounded) for write_enable; lat counts low cycles seen before it.
  task automatic wait_we(output bit seen, output int lat);
    seen = 1'b0;
    lat  = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (write_enable === 1'b1) begin
        seen = 1'b1;
        break;
      end
      lat++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_total++; if (data_out !== 32'h0) $display("FAIL reset_data: got %h want 0", data_out); else n_pass++;
    n_total++; if ({write_enable, game_start, recording} !== 3'b000)
      $display("FAIL reset_strobes: got %b want 000", {write_enable, game_start, recording}); else n_pass++;
    n_total++; if ({piezo_out, led_out, note_count} !== 12'h000)
      $display("FAIL reset_echo_count: got %h want 000", {piezo_out, led_out, note_count}); else n_pass++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_song();
    logic [3:0]  keys [8];
    logic [31:0] exp_v;
    bit seen; int lat; int extra;
    keys = '{4'd3, 4'd1, 4'd4, 4'd1, 4'd5, 4'd2, 4'd6, 4'd8};
    for (int i = 0; i < 7; i++) begin
      press(keys[i], 3);
      n_total++; if (note_count !== 4'(i + 1))
        $display("FAIL t1_count_%0d: got %0d want %0d", i, note_count, i + 1); else n_pass++;
    end
    n_total++; if (recording !== 1'b1) $display("FAIL t1_recording: got %b want 1", recording); else n_pass++;
    keypad_input  = keys[7];
    keypad_enable = 1'b1;
    exp_q.push_back(32'h7514_0302);
    wait_we(seen, lat);
    keypad_enable = 1'b0;
    keypad_input  = 4'd0;
    exp_v = exp_q.pop_front();
    n_total++; if (!seen) $display("FAIL t1_we_timeout: got no write_enable want one"); else n_pass++;
    n_total++; if (lat !== DLY * TICK + 1) $display("FAIL t1_latency: got %0d want %0d", lat, DLY * TICK + 1); else n_pass++;
    n_total++; if (data_out !== exp_v) $display("FAIL t1_data: got %h want %h", data_out, exp_v); else n_pass++;
    @(negedge clk);
    n_total++; if ({write_enable, game_start} !== 2'b01)
      $display("FAIL t1_game_start: got we,gs=%b want 01", {write_enable, game_start}); else n_pass++;
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (write_enable || game_start) extra++;
    end
    n_total++; if (extra !== 0) $display("FAIL t1_single_pulse: got %0d extra strobes want 0", extra); else n_pass++;
    n_total++; if (data_out !== exp_v) $display("FAIL t1_done_hold: got %h want %h", data_out, exp_v); else n_pass++;
  endtask

  task automatic test_invalid_keys();
    do_clear();
    keypad_input = 4'd9; keypad_enable = 1'b1;
    @(negedge clk);
    n_total++; if ({piezo_out, note_count, 3'b000, recording} !== 12'h000)
      $display("FAIL t3_key9: got echo,count,rec=%h want 000", {piezo_out, note_count, 3'b000, recording}); else n_pass++;
    keypad_enable = 1'b0;
    @(negedge clk);
    keypad_input = 4'd0; keypad_enable = 1'b1;
    @(negedge clk);
    n_total++; if ({piezo_out, note_count} !== 8'h00)
      $display("FAIL t3_key0: got echo,count=%h want 00", {piezo_out, note_count}); else n_pass++;
    keypad_enable = 1'b0;
    @(negedge clk);
    keypad_input = 4'd5; keypad_enable = 1'b1;
    @(negedge clk);
    n_total++; if ({piezo_out, led_out} !== 8'h55) $display("FAIL t3_echo5: got %h want 55", {piezo_out, led_out}); else n_pass++;
    n_total++; if (note_count !== 4'd1) $display("FAIL t3_count5: got %0d want 1", note_count); else n_pass++;
    @(negedge clk);
    n_total++; if (piezo_out !== 4'd5) $display("FAIL t3_echo_held: got %0d want 5", piezo_out); else n_pass++;
    keypad_enable = 1'b0;
    @(negedge clk);
    n_total++; if ({piezo_out, led_out} !== 8'h00) $display("FAIL t3_release: got %h want 00", {piezo_out, led_out}); else n_pass++;
  endtask

`ifndef SONG_RANDOM_FILL_EN
  task automatic test_commit_pad();
    logic [31:0] exp_v;
    bit seen; int lat; int extra;
    do_clear();
    press(4'd2, 3); press(4'd7, 3); press(4'd4, 3);
    commit = 1'b1;
    exp_q.push_back(32'h3333_3361);
    @(negedge clk);
    commit = 1'b0;
    wait_we(seen, lat);
    exp_v = exp_q.pop_front();
    n_total++; if (!seen) $display("FAIL t2_we_timeout: got no write_enable want one"); else n_pass++;
    n_total++; if (data_out !== exp_v) $display("FAIL t2_data: got %h want %h", data_out, exp_v); else n_pass++;
    n_total++; if (note_count !== 4'd3) $display("FAIL t2_count: got %0d want 3", note_count); else n_pass++;
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (write_enable) extra++;
    end
    n_total++; if (extra !== 0) $display("FAIL t2_single_we: got %0d extra want 0", extra); else n_pass++;
  endtask

  task automatic test_min_notes();
    logic [31:0] exp_v;
    bit seen; int lat; int early;
    do_clear();
    press(4'd2, 3); press(4'd3, 3);
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    early = 0;
    repeat (12) begin
      @(negedge clk);
      if (write_enable || !recording) early++;
    end
    n_total++; if (early !== 0) $display("FAIL t4_early_commit: got %0d bad cycles want 0", early); else n_pass++;
    n_total++; if (note_count !== 4'd2) $display("FAIL t4_count2: got %0d want 2", note_count); else n_pass++;
    press(4'd4, 3);
    commit = 1'b1;
    exp_q.push_back(32'h3333_3321);
    @(negedge clk);
    commit = 1'b0;
    wait_we(seen, lat);
    exp_v = exp_q.pop_front();
    n_total++; if (!seen) $display("FAIL t4_we_timeout: got no write_enable want one"); else n_pass++;
    n_total++; if (data_out !== exp_v) $display("FAIL t4_data: got %h want %h", data_out, exp_v); else n_pass++;
  endtask

  task automatic test_commit_vs_key();
    logic [31:0] exp_v;
    bit seen; int lat;
    do_clear();
    press(4'd1, 3); press(4'd2, 3); press(4'd3, 3);
    keypad_input = 4'd6; keypad_enable = 1'b1; commit = 1'b1;
    exp_q.push_back(32'h2222_2210);
    @(negedge clk);
    commit = 1'b0;
    n_total++; if ({piezo_out, note_count} !== 8'h03)
      $display("FAIL tc_key_discard: got echo,count=%h want 03", {piezo_out, note_count}); else n_pass++;
    n_total++; if (recording !== 1'b0) $display("FAIL tc_left_record: got %b want 0", recording); else n_pass++;
    keypad_enable = 1'b0; keypad_input = 4'd0;
    wait_we(seen, lat);
    exp_v = exp_q.pop_front();
    n_total++; if (!seen) $display("FAIL tc_we_timeout: got no write_enable want one"); else n_pass++;
    n_total++; if (data_out !== exp_v) $display("FAIL tc_data: got %h want %h", data_out, exp_v); else n_pass++;
  endtask
`else
  task automatic test_random_fill();
    logic [31:0] exp_v;
    bit seen; int lat;
    do_clear();
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    exp_v = '0;
    for (int k = 0; k < 8; k++) begin
      exp_v[4*k +: 4] = {1'b0, mdl_lfsr[2:0]};
      @(negedge clk);
    end
    exp_q.push_back(exp_v);
    wait_we(seen, lat);
    exp_v = exp_q.pop_front();
    n_total++; if (!seen) $display("FAIL t6_we_timeout: got no write_enable want one"); else n_pass++;
    n_total++; if (data_out !== exp_v) $display("FAIL t6_data: got %h want %h", data_out, exp_v); else n_pass++;
    n_total++; if (note_count !== 4'd0) $display("FAIL t6_count: got %0d want 0", note_count); else n_pass++;
  endtask
`endif

  task automatic test_reset_in_wait();
    logic [3:0]  keys [8];
    logic [31:0] exp_v;
    bit seen; int lat; int strobes;
    keys = '{4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
    do_clear();
    for (int i = 0; i < 8; i++) press(keys[i], 3);
    reset = 1'b1;
    #1;
    n_total++; if ({data_out, write_enable, game_start, piezo_out, led_out, note_count, recording} !== 47'h0)
      $display("FAIL t5_async_reset: got data=%h cnt=%0d want all 0", data_out, note_count); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    strobes = 0;
    repeat (30) begin
      @(negedge clk);
      if (write_enable || game_start) strobes++;
    end
    n_total++; if (strobes !== 0) $display("FAIL t5_suppressed: got %0d strobes want 0", strobes); else n_pass++;
    // Back-to-back song after the reset.
    exp_q.push_back(32'h0123_4567);
    for (int i = 0; i < 8; i++) press(keys[i], 3);
    wait_we(seen, lat);
    exp_v = exp_q.pop_front();
    n_total++; if (!seen) $display("FAIL t5_we_timeout: got no write_enable want one"); else n_pass++;
    n_total++; if (data_out !== exp_v) $display("FAIL t5_data: got %h want %h", data_out, exp_v); else n_pass++;
    repeat (3) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    n_total++; if ({data_out, note_count, recording} !== 37'h0)
      $display("FAIL t5_clear_done: got data=%h cnt=%0d rec=%b want 0", data_out, note_count, recording); else n_pass++;
    press(4'd2, 3);
    n_total++; if ({recording, note_count} !== 5'b1_0001)
      $display("FAIL t5_idle_after_clear: got rec,cnt=%b want 10001", {recording, note_count}); else n_pass++;
  endtask

  initial begin
    reset = 1'b1; keypad_input = 4'd0; keypad_enable = 1'b0; commit = 1'b0; clear = 1'b0;
    test_reset();
    test_full_song();
    test_invalid_keys();
`ifndef SONG_RANDOM_FILL_EN
    test_commit_pad();
    test_min_notes();
    test_commit_vs_key();
`else
    test_random_fill();
`endif
    test_reset_in_wait();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
